// File: rtl/ipsxb_uart_tx_32bit_pkg.sv
// Shared definitions for the UART transmitter: FSM state encodings, parity modes
// and the parity helper used when a byte is loaded into the shifter.
package ipsxb_uart_tx_32bit_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   // Data is pre-masked to DATA_BITS, so reducing over all 8 bits is safe.
   function automatic logic parity_bit(input logic [7:0] data, input int mode);
      parity_bit = (mode == PARITY_ODD) ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/ipsxb_uart_tx_32bit.sv
// UART transmitter: LSB-first framing with start, 5-8 data, optional parity and
// 1-2 stop bits, advanced by clk_en; a one-entry hold allows back-to-back frames.
module ipsxb_uart_tx_32bit
   import ipsxb_uart_tx_32bit_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_en,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       txd
);

   localparam logic [7:0] DATA_MASK  = 8'((16'd1 << DATA_BITS) - 16'd1);
   localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);
   localparam bit         HAS_PARITY = (PARITY != PARITY_NONE);

   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("ipsxb_uart_tx_32bit: DATA_BITS must be 5..8");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("ipsxb_uart_tx_32bit: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("ipsxb_uart_tx_32bit: STOP_BITS must be 1 or 2");
   end

   tx_state_t  state_reg, state_next;
   logic [2:0] bit_cnt_reg, bit_cnt_next;
   logic       stop_cnt_reg, stop_cnt_next;
   logic [7:0] shift_reg, shift_next;
   logic       parity_reg, parity_next;
   logic       txd_reg, txd_next;

   logic [7:0] hold_reg;
   logic       hold_full_reg;
   logic       tx_ready_reg;
   logic       accept;
   logic       load;

   assign accept   = tx_valid & tx_ready_reg;
   assign tx_ready = tx_ready_reg;
   assign tx_busy  = (state_reg != ST_IDLE) | hold_full_reg;
   assign txd      = txd_reg;

   // Accept can only happen with the hold empty and load only with it full,
   // so the two branches never compete.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
         tx_ready_reg  <= 1'b1;
      end else if (accept) begin
         hold_reg      <= tx_data & DATA_MASK;
         hold_full_reg <= 1'b1;
         tx_ready_reg  <= 1'b0;
      end else if (load) begin
         hold_full_reg <= 1'b0;
         tx_ready_reg  <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         bit_cnt_reg  <= '0;
         stop_cnt_reg <= 1'b0;
         shift_reg    <= '0;
         parity_reg   <= 1'b0;
         txd_reg      <= 1'b1;
      end else begin
         state_reg    <= state_next;
         bit_cnt_reg  <= bit_cnt_next;
         stop_cnt_reg <= stop_cnt_next;
         shift_reg    <= shift_next;
         parity_reg   <= parity_next;
         txd_reg      <= txd_next;
      end
   end

   // txd_next is the level of the bit period that begins at this clk_en edge.
   always_comb begin
      state_next    = state_reg;
      bit_cnt_next  = bit_cnt_reg;
      stop_cnt_next = stop_cnt_reg;
      shift_next    = shift_reg;
      parity_next   = parity_reg;
      txd_next      = txd_reg;
      load          = 1'b0;

      if (clk_en) begin
         case (state_reg)
            ST_IDLE: begin
               txd_next = 1'b1;
               load     = hold_full_reg;
            end
            ST_START: begin
               state_next   = ST_DATA;
               bit_cnt_next = '0;
               txd_next     = shift_reg[0];
               shift_next   = shift_reg >> 1;
            end
            ST_DATA: begin
               if (bit_cnt_reg == LAST_BIT) begin
                  if (HAS_PARITY) begin
                     state_next = ST_PARITY;
                     txd_next   = parity_reg;
                  end else begin
                     state_next    = ST_STOP;
                     stop_cnt_next = 1'b0;
                     txd_next      = 1'b1;
                  end
               end else begin
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  txd_next     = shift_reg[0];
                  shift_next   = shift_reg >> 1;
               end
            end
            ST_PARITY: begin
               state_next    = ST_STOP;
               stop_cnt_next = 1'b0;
               txd_next      = 1'b1;
            end
            ST_STOP: begin
               txd_next = 1'b1;
               if (stop_cnt_reg == LAST_STOP) begin
                  if (hold_full_reg) begin
                     load = 1'b1;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end else begin
                  stop_cnt_next = stop_cnt_reg + 1'b1;
               end
            end
            default: begin
               state_next = ST_IDLE;
               txd_next   = 1'b1;
            end
         endcase

         if (load) begin
            state_next  = ST_START;
            txd_next    = 1'b0;
            shift_next  = hold_reg;
            parity_next = parity_bit(hold_reg, PARITY);
         end
      end
   end

endmodule

// File: tb/tb_ipsxb_uart_tx_32bit.sv
// Self-checking bench: four transmitter configurations side by side, each compared
// every cycle against a bit-queue model of the serial line, plus literal frame checks.
module tb_ipsxb_uart_tx_32bit;

   localparam int NCFG  = 4;
   localparam int LIMIT = 4000;
   // 8N1/div4, 8O2/div4, 8E1/div1, 5N1/div4
   localparam int CFG_DB  [NCFG] = '{8, 8, 8, 5};
   localparam int CFG_PAR [NCFG] = '{0, 1, 2, 0};
   localparam int CFG_SB  [NCFG] = '{1, 2, 1, 1};
   localparam int CFG_DIV [NCFG] = '{4, 4, 1, 4};
   // Hand-computed first frames; bit k is the line level in bit period k.
   localparam logic [7:0]  LIT_BYTE [NCFG] = '{8'hA5, 8'h03, 8'h03, 8'hFF};
   localparam int          LIT_LEN  [NCFG] = '{10, 12, 11, 7};
   localparam logic [15:0] LIT_BITS [NCFG] = '{16'h034A, 16'h0E06, 16'h0406, 16'h007E};

   logic clk = 1'b0;
   int   total = 0;
   int   bad   = 0;
   bit   done [NCFG];

   initial forever #5 clk = ~clk;

   task automatic check(input int cfg, input string name,
                        input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL cfg%0d %s: got %0h want %0h at %0t", cfg, name, act, exp, $time);
      end
   endtask

   genvar gi;
   generate
      for (gi = 0; gi < NCFG; gi++) begin : g_cfg
         localparam int DB  = CFG_DB[gi];
         localparam int PAR = CFG_PAR[gi];
         localparam int SB  = CFG_SB[gi];
         localparam int DIV = CFG_DIV[gi];

         logic       rst_n    = 1'b0;
         logic       clk_en   = 1'b0;
         logic [7:0] tx_data  = 8'h00;
         logic       tx_valid = 1'b0;
         logic       tx_ready, tx_busy, txd;
         int         en_cnt   = 0;

         ipsxb_uart_tx_32bit #(.DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .clk_en   (clk_en),
            .tx_data  (tx_data),
            .tx_valid (tx_valid),
            .tx_ready (tx_ready),
            .tx_busy  (tx_busy),
            .txd      (txd)
         );

         always @(negedge clk) begin
            en_cnt <= (en_cnt == DIV - 1) ? 0 : en_cnt + 1;
            clk_en <= (en_cnt == DIV - 1);
         end

         // Line model: bits_q holds the rest of the frame on the wire, hold_q the waiting byte.
         bit         bits_q [$];
         logic [7:0] hold_q [$];
         bit         exp_txd  = 1'b1;
         bit         in_frame = 1'b0;

         always @(posedge clk) begin
            bit ready_pre;
            int ones;
            logic [7:0] d;
            if (!rst_n) begin
               bits_q.delete();
               hold_q.delete();
               exp_txd  = 1'b1;
               in_frame = 1'b0;
            end else begin
               ready_pre = (hold_q.size() == 0);
               if (clk_en) begin
                  if (bits_q.size() > 0) begin
                     exp_txd = bits_q.pop_front();
                  end else if (hold_q.size() > 0) begin
                     d = hold_q.pop_front();
                     ones = 0;
                     exp_txd  = 1'b0;
                     in_frame = 1'b1;
                     for (int i = 0; i < DB; i++) begin
                        bits_q.push_back(d[i]);
                        ones += int'(d[i]);
                     end
                     if (PAR == 1) bits_q.push_back(ones % 2 == 0);
                     if (PAR == 2) bits_q.push_back(ones % 2 == 1);
                     for (int i = 0; i < SB; i++) bits_q.push_back(1'b1);
                  end else begin
                     exp_txd  = 1'b1;
                     in_frame = 1'b0;
                  end
               end
               if (ready_pre && tx_valid) hold_q.push_back(tx_data);
            end
            #1;
            check(gi, "txd", txd, exp_txd);
            check(gi, "tx_ready", tx_ready, hold_q.size() == 0);
            check(gi, "tx_busy", tx_busy, in_frame || hold_q.size() > 0);
         end

         task automatic wait_accept();
            int n = 0;
            while (tx_ready !== 1'b1 && n < LIMIT) begin
               @(negedge clk);
               n++;
            end
            check(gi, "ready_wait_ok", n < LIMIT, 1);
            @(negedge clk);
         endtask

         task automatic send(input logic [7:0] d);
            tx_data  = d;
            tx_valid = 1'b1;
            wait_accept();
            tx_valid = 1'b0;
         endtask

         task automatic wait_idle();
            int n = 0;
            while (tx_busy !== 1'b0 && n < LIMIT) begin
               @(negedge clk);
               n++;
            end
            check(gi, "idle_wait_ok", n < LIMIT, 1);
            @(negedge clk);
         endtask

         task automatic capture_literal();
            logic [15:0] cap = '0;
            int k = 0;
            int n = 0;
            bit en;
            send(LIT_BYTE[gi]);
            while (k < LIT_LEN[gi] && n < LIMIT) begin
               @(posedge clk);
               en = clk_en;
               #1;
               if (en) begin
                  cap[k] = txd;
                  k++;
               end
               n++;
            end
            check(gi, "frame_literal", cap, LIT_BITS[gi]);
            wait_idle();
         endtask

         initial begin
            int k;
            int n;
            // Reset held with tx_valid asserted: nothing may be accepted.
            tx_valid = 1'b1;
            tx_data  = 8'h3C;
            repeat (6) @(negedge clk);
            check(gi, "rst_txd", txd, 1);
            check(gi, "rst_ready", tx_ready, 1);
            check(gi, "rst_busy", tx_busy, 0);
            tx_valid = 1'b0;
            rst_n    = 1'b1;
            repeat (3) @(negedge clk);

            capture_literal();

            // Back-to-back with tx_valid held high across both bytes.
            tx_data  = 8'h00;
            tx_valid = 1'b1;
            wait_accept();
            tx_data  = 8'hFF;
            wait_accept();
            tx_valid = 1'b0;
            wait_idle();

            // Abort mid-DATA: three clk_en edges in, the line carries data bit 1 (0).
            send(8'h55);
            k = 0;
            n = 0;
            while (k < 3 && n < LIMIT) begin
               @(posedge clk);
               if (clk_en) k++;
               n++;
            end
            @(negedge clk);
            check(gi, "mid_txd_low", txd, 0);
            rst_n    = 1'b0;
            tx_valid = 1'b1;
            #1;
            check(gi, "abort_txd", txd, 1);
            check(gi, "abort_ready", tx_ready, 1);
            check(gi, "abort_busy", tx_busy, 0);
            repeat (3) @(negedge clk);
            tx_valid = 1'b0;
            rst_n    = 1'b1;
            @(negedge clk);
            capture_literal();

            // Random traffic with random gaps and occasional held-valid streaks.
            for (int t = 0; t < 25; t++) begin
               tx_data  = 8'($urandom);
               tx_valid = 1'b1;
               wait_accept();
               if ($urandom_range(0, 2) != 0) begin
                  tx_valid = 1'b0;
                  tx_data  = 8'($urandom);
                  repeat ($urandom_range(0, 3 * DIV)) @(negedge clk);
               end
            end
            tx_valid = 1'b0;
            wait_idle();
            done[gi] = 1'b1;
         end
      end
   endgenerate

   initial begin
      int n = 0;
      bit all_done = 1'b0;
      while (!all_done && n < 80000) begin
         @(negedge clk);
         n++;
         all_done = 1'b1;
         for (int i = 0; i < NCFG; i++) if (!done[i]) all_done = 1'b0;
      end
      check(-1, "all_done", all_done, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
